// File: rtl/paint_pkg.sv
// Shared types and helpers for the brush/cursor paint datapath.
package paint_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAINT = 2'd1,
        CLEAR = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_NEG  = 2'b01,
        DIR_POS  = 2'b10
    } dir_t;

    // Active-low button pair to an axis direction; both or neither pressed cancel out.
    function automatic dir_t axis_dir(input logic neg_n, input logic pos_n);
        dir_t d;
        d = DIR_NONE;
        if (!neg_n && pos_n)
            d = DIR_NEG;
        else if (neg_n && !pos_n)
            d = DIR_POS;
        return d;
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        int r;
        r = v;
        if (v < lo)
            r = lo;
        else if (v > hi)
            r = hi;
        return r;
    endfunction

endpackage

// File: rtl/rect_scanner.sv
// Row-major rectangle walker, one coordinate per cycle; shared by brush paint and buffer clear.
module rect_scanner #(
    parameter int COORD_W = 11
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] base_x,
    input  logic [COORD_W-1:0] base_y,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               valid,
    output logic               done
);

    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x_last;
    logic [COORD_W-1:0] y_last;

    assign x_last = x0 + width - 1'b1;
    assign y_last = y0 + height - 1'b1;
    assign done   = valid && (x == x_last) && (y == y_last);

    // Comes out of reset already scanning from (0,0): the owner starts in CLEAR.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            valid <= 1'b1;
            x     <= '0;
            y     <= '0;
            x0    <= '0;
            y0    <= '0;
        end else if (start) begin
            valid <= 1'b1;
            x     <= base_x;
            y     <= base_y;
            x0    <= base_x;
            y0    <= base_y;
        end else if (abort || done) begin
            valid <= 1'b0;
        end else if (valid) begin
            if (x == x_last) begin
                x <= x0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/brush_engine.sv
// Cursor movement with hold-acceleration plus brush paint / full clear write-address generation.
module brush_engine
    import paint_pkg::*;
#(
    parameter int W_RES      = 640,
    parameter int H_RES      = 480,
    parameter int COORD_W    = 11,
    parameter int STEP       = 4,
    parameter int DIVISOR    = 2000000,
    parameter int SIZE_DEF   = 8,
    parameter int SIZE_MAX   = 16,
    parameter int SIZE_W     = 5,
    parameter int HOLD_TICKS = 8
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               up_n,
    input  logic               down_n,
    input  logic               left_n,
    input  logic               right_n,
    input  logic [SIZE_W-1:0]  brush_size,
    input  logic               paint_en,
    input  logic               clear_req,
    output logic [COORD_W-1:0] cursor_x,
    output logic [COORD_W-1:0] cursor_y,
    output logic [COORD_W-1:0] wr_x,
    output logic [COORD_W-1:0] wr_y,
    output logic               wr_en,
    output logic               wr_clear,
    output logic               busy
);

    localparam int SZ_WH  = (W_RES < H_RES) ? W_RES : H_RES;
    localparam int SZ_LIM = (SIZE_MAX < SZ_WH) ? SIZE_MAX : SZ_WH;
    localparam int TICK_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    state_t              state, state_n;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic [SIZE_W-1:0]   size_q;
    logic [HOLD_W-1:0]   hold_q;
    dir_t                pdx, pdy, dx, dy;
    logic                moving, same, fast, take_tick, last_q;
    int                  size_n;
    logic signed [COORD_W:0] step_s, off_x, off_y, nx_s, ny_s;
    logic [COORD_W-1:0]  next_x, next_y;

    logic                scan_start, scan_abort, scan_valid, scan_done;
    logic [COORD_W-1:0]  scan_bx, scan_by, scan_w, scan_h, scan_x, scan_y;

    assign tick   = (tick_cnt == TICK_W'(DIVISOR - 1));
    assign dx     = axis_dir(left_n, right_n);
    assign dy     = axis_dir(up_n, down_n);
    assign moving = (dx != DIR_NONE) || (dy != DIR_NONE);
    assign same   = moving && (dx == pdx) && (dy == pdy);
    // Fast step only continues an unbroken run in the same direction.
    assign fast   = same && (hold_q >= HOLD_W'(HOLD_TICKS));
    assign busy   = (state != IDLE);

    always_comb begin
        size_n = clamp(int'(brush_size), 1, SZ_LIM);
        step_s = fast ? (COORD_W+1)'(4 * STEP) : (COORD_W+1)'(STEP);
        case (dx)
            DIR_NEG: off_x = -step_s;
            DIR_POS: off_x = step_s;
            default: off_x = '0;
        endcase
        case (dy)
            DIR_NEG: off_y = -step_s;
            DIR_POS: off_y = step_s;
            default: off_y = '0;
        endcase
        nx_s   = $signed({1'b0, cursor_x}) + off_x;
        ny_s   = $signed({1'b0, cursor_y}) + off_y;
        next_x = COORD_W'(clamp(int'(nx_s), 0, W_RES - size_n));
        next_y = COORD_W'(clamp(int'(ny_s), 0, H_RES - size_n));
    end

    always_comb begin
        state_n    = state;
        take_tick  = 1'b0;
        scan_start = 1'b0;
        scan_abort = 1'b0;
        scan_bx    = '0;
        scan_by    = '0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_n    = CLEAR;
                    scan_start = 1'b1;
                end else if (tick) begin
                    take_tick = 1'b1;
                    if (paint_en) begin
                        state_n    = PAINT;
                        scan_start = 1'b1;
                        scan_bx    = next_x;
                        scan_by    = next_y;
                    end
                end
            end
            PAINT: begin
                if (clear_req) begin
                    state_n    = CLEAR;
                    scan_start = 1'b1;
                    scan_abort = 1'b1;
                end else if (last_q) begin
                    state_n = IDLE;
                end
            end
            CLEAR: if (last_q) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Paint dimensions come from size_q, which updates on the same edge the scan starts.
    assign scan_w = (state == PAINT) ? COORD_W'(size_q) : COORD_W'(W_RES);
    assign scan_h = (state == PAINT) ? COORD_W'(size_q) : COORD_W'(H_RES);

    rect_scanner #(.COORD_W(COORD_W)) u_scan (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (scan_start),
        .abort    (scan_abort),
        .base_x   (scan_bx),
        .base_y   (scan_by),
        .width    (scan_w),
        .height   (scan_h),
        .x        (scan_x),
        .y        (scan_y),
        .valid    (scan_valid),
        .done     (scan_done)
    );

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state    <= CLEAR;
            tick_cnt <= '0;
            size_q   <= SIZE_W'(SIZE_DEF);
            hold_q   <= '0;
            pdx      <= DIR_NONE;
            pdy      <= DIR_NONE;
            cursor_x <= COORD_W'(W_RES / 2 - SIZE_DEF / 2);
            cursor_y <= COORD_W'(H_RES / 2 - SIZE_DEF / 2);
            wr_x     <= '0;
            wr_y     <= '0;
            wr_en    <= 1'b0;
            wr_clear <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            // The write stage trails the scanner by one cycle; last_q marks the final write.
            wr_x     <= scan_x;
            wr_y     <= scan_y;
            wr_en    <= scan_valid && !scan_abort;
            wr_clear <= scan_valid && (state == CLEAR);
            last_q   <= scan_done && !scan_abort;
            if (take_tick) begin
                size_q   <= SIZE_W'(size_n);
                cursor_x <= next_x;
                cursor_y <= next_y;
                pdx      <= dx;
                pdy      <= dy;
                if (!moving)
                    hold_q <= '0;
                else if (!same)
                    hold_q <= HOLD_W'(1);
                else if (hold_q != HOLD_W'(HOLD_TICKS))
                    hold_q <= hold_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_brush_engine.sv
// Directed bench for brush_engine at a reduced 16x8 resolution.
module tb_brush_engine;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int CW = 11;

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b0;
    logic          up_n = 1'b1, down_n = 1'b1, left_n = 1'b1, right_n = 1'b1;
    logic [4:0]    brush_size = 5'd2;
    logic          paint_en = 1'b0, clear_req = 1'b0;
    logic [CW-1:0] cursor_x, cursor_y, wr_x, wr_y;
    logic          wr_en, wr_clear, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_cnt;

    typedef struct {
        int x;
        int y;
        bit c;
    } wr_t;
    wr_t wq[$];

    // btn = {up, down, left, right}, 1 = pressed; esz = painted edge, 0 = no paint expected
    typedef struct {
        bit         rst;
        logic [3:0] btn;
        int         size;
        bit         pe;
        int         ex;
        int         ey;
        int         esz;
    } vec_t;
    vec_t vecs[14];

    brush_engine #(
        .W_RES(W), .H_RES(H), .COORD_W(CW), .STEP(2), .DIVISOR(4),
        .SIZE_DEF(2), .SIZE_MAX(4), .SIZE_W(5), .HOLD_TICKS(3)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .up_n(up_n), .down_n(down_n), .left_n(left_n), .right_n(right_n),
        .brush_size(brush_size), .paint_en(paint_en), .clear_req(clear_req),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .wr_x(wr_x), .wr_y(wr_y), .wr_en(wr_en), .wr_clear(wr_clear), .busy(busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference movement-tick phase: a tick is taken on the edge ending a cycle with count 3.
    always @(posedge CLOCK_50 or negedge reset)
        if (!reset) tb_cnt <= 0;
        else        tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_idle_inputs();
        up_n = 1'b1; down_n = 1'b1; left_n = 1'b1; right_n = 1'b1;
        paint_en = 1'b0; clear_req = 1'b0;
    endtask

    task automatic collect();
        bit ended;
        ended = 1'b0;
        wq.delete();
        for (int i = 0; i < 400 && !ended; i++) begin
            @(negedge CLOCK_50);
            if (wr_en) wq.push_back('{int'(wr_x), int'(wr_y), wr_clear});
            if (!busy) ended = 1'b1;
        end
        if (!ended) check("collect_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_raster(input string name, input int base, input int x0, input int y0,
                                input int w, input int h, input bit clr);
        for (int i = 0; i < w * h; i++) begin
            if (base + i < wq.size()) begin
                n_checks++;
                if (wq[base+i].x != x0 + i % w || wq[base+i].y != y0 + i / w || wq[base+i].c != clr) begin
                    n_fail++;
                    $display("FAIL %s[%0d]: got (%0d,%0d,clr=%0d), expected (%0d,%0d,clr=%0d)", name, i,
                             wq[base+i].x, wq[base+i].y, wq[base+i].c, x0 + i % w, y0 + i / w, clr);
                end
            end
        end
    endtask

    // Call from a point where tb_cnt holds the current cycle's count (at a negedge or just after a posedge).
    task automatic wait_tick(input bit with_clear);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 8 && !hit; i++) begin
            if (tb_cnt == 3) begin
                clear_req = with_clear;
                @(posedge CLOCK_50);
                #1;
                hit = 1'b1;
            end else begin
                @(negedge CLOCK_50);
            end
        end
        if (!hit) check("tick_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b0;
        set_idle_inputs();
        #1;
        check("rst_busy", busy, 1);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_clear", wr_clear, 0);
        check("rst_wr_xy", {wr_x, wr_y}, 0);
        check("rst_cursor_x", cursor_x, 7);
        check("rst_cursor_y", cursor_y, 3);
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b1;
        collect();
        check("rst_clear_count", wq.size(), W * H);
        check_raster("rst_clear", 0, 0, 0, W, H, 1'b1);
        check("rst_idle_busy", busy, 0);
        check("rst_idle_cursor_x", cursor_x, 7);
        check("rst_idle_cursor_y", cursor_y, 3);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'b0001, 2,  1'b0, 9,  3, 0};
        vecs[1]  = '{1'b0, 4'b0001, 2,  1'b0, 11, 3, 0};
        vecs[2]  = '{1'b0, 4'b0001, 2,  1'b0, 13, 3, 0};
        vecs[3]  = '{1'b0, 4'b0001, 2,  1'b0, 14, 3, 0};
        vecs[4]  = '{1'b1, 4'b1010, 2,  1'b0, 5,  1, 0};
        vecs[5]  = '{1'b0, 4'b1010, 2,  1'b0, 3,  0, 0};
        vecs[6]  = '{1'b1, 4'b0000, 3,  1'b1, 7,  3, 3};
        vecs[7]  = '{1'b0, 4'b0000, 0,  1'b1, 7,  3, 1};
        vecs[8]  = '{1'b0, 4'b0101, 2,  1'b0, 9,  5, 0};
        vecs[9]  = '{1'b0, 4'b0101, 2,  1'b0, 11, 6, 0};
        vecs[10] = '{1'b0, 4'b0001, 2,  1'b0, 13, 6, 0};
        vecs[11] = '{1'b0, 4'b0001, 2,  1'b0, 14, 6, 0};
        vecs[12] = '{1'b0, 4'b0000, 31, 1'b1, 12, 4, 4};
        vecs[13] = '{1'b0, 4'b1011, 2,  1'b0, 12, 2, 0};

        do_reset();

        for (int v = 0; v < 14; v++) begin
            if (vecs[v].rst) do_reset();
            up_n       = ~vecs[v].btn[3];
            down_n     = ~vecs[v].btn[2];
            left_n     = ~vecs[v].btn[1];
            right_n    = ~vecs[v].btn[0];
            brush_size = 5'(vecs[v].size);
            paint_en   = vecs[v].pe;
            wait_tick(1'b0);
            collect();
            set_idle_inputs();
            check($sformatf("v%0d_cursor_x", v), cursor_x, vecs[v].ex);
            check($sformatf("v%0d_cursor_y", v), cursor_y, vecs[v].ey);
            check($sformatf("v%0d_wr_count", v), wq.size(), vecs[v].esz * vecs[v].esz);
            check_raster($sformatf("v%0d_paint", v), 0, vecs[v].ex, vecs[v].ey, vecs[v].esz, vecs[v].esz, 1'b0);
        end

        // clear_req coinciding with a tick in IDLE: clear only, no move, no paint
        right_n = 1'b0; paint_en = 1'b1; brush_size = 5'd2;
        wait_tick(1'b1);
        clear_req = 1'b0;
        collect();
        set_idle_inputs();
        check("prio_clear_count", wq.size(), W * H);
        check_raster("prio_clear", 0, 0, 0, W, H, 1'b1);
        check("prio_cursor_x", cursor_x, 12);
        check("prio_cursor_y", cursor_y, 2);

        // Paint aborted on its 4th write, then a clear that ignores a mid-clear request
        brush_size = 5'd3; paint_en = 1'b1;
        wait_tick(1'b0);
        paint_en = 1'b0;
        wq.delete();
        begin
            bit ended;
            ended = 1'b0;
            for (int i = 0; i < 600 && !ended; i++) begin
                @(negedge CLOCK_50);
                if (clear_req) clear_req = 1'b0;
                if (wr_en) begin
                    wq.push_back('{int'(wr_x), int'(wr_y), wr_clear});
                    if (wq.size() == 4 || wq.size() == 44) clear_req = 1'b1;
                end
                if (!busy) ended = 1'b1;
            end
            if (!ended) check("abort_timeout", 32'd1, 32'd0);
        end
        set_idle_inputs();
        check("abort_total_writes", wq.size(), 4 + W * H);
        check_raster("abort_paint", 0, 12, 2, 3, 1, 1'b0);
        if (wq.size() > 3) begin
            n_checks++;
            if (wq[3].x != 12 || wq[3].y != 3 || wq[3].c != 1'b0) begin
                n_fail++;
                $display("FAIL abort_paint[3]: got (%0d,%0d,clr=%0d), expected (12,3,clr=0)",
                         wq[3].x, wq[3].y, wq[3].c);
            end
        end
        check_raster("abort_clear", 4, 0, 0, W, H, 1'b1);
        check("abort_cursor_x", cursor_x, 12);
        check("abort_cursor_y", cursor_y, 2);

        // Reset in the middle of a paint returns to reset state and re-clears
        brush_size = 5'd4; paint_en = 1'b1;
        wait_tick(1'b0);
        paint_en = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("midrst_busy_before", busy, 1);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/brush_engine.md
Name: brush_engine

Overview:
Parametrised cursor/brush controller for the paint datapath. It replaces the fixed cursor, paint and zero-buffer logic with one block. The block moves the cursor from active-low buttons, with diagonal movement and hold-acceleration. It emits one frame-buffer write address per cycle for two jobs: painting a square brush of selectable size, and clearing the whole buffer. Its outputs drive the write ports of the R/G/B buffers; the pixel colour comes from outside.

Parameters:
W_RES, 640, horizontal resolution in pixels
H_RES, 480, vertical resolution in pixels
COORD_W, 11, coordinate width
STEP, 4, cursor step per tick in pixels
DIVISOR, 2000000, CLOCK_50 cycles per movement tick
SIZE_DEF, 8, brush size at reset
SIZE_MAX, 16, largest brush edge in pixels
SIZE_W, 5, width of brush_size
HOLD_TICKS, 8, consecutive same-direction ticks before the step becomes 4*STEP

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-low reset
up_n, down_n, left_n, right_n  in  1 each  buttons, active-low
brush_size  in  SIZE_W  requested brush edge; sampled on each tick
paint_en  in  1  when high, paint the brush after each tick
clear_req  in  1  request a full-buffer clear; level-sampled in IDLE and PAINT
cursor_x, cursor_y  out  COORD_W  top-left corner of the brush
wr_x, wr_y  out  COORD_W  buffer write coordinate
wr_en  out  1  buffer write strobe
wr_clear  out  1  when high, the write data must be black (0)
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (reset=0):
  - state=CLEAR, scan counters=0, tick counter=0, size_q=SIZE_DEF, hold count=0.
  - cursor=(W_RES/2-SIZE_DEF/2, H_RES/2-SIZE_DEF/2).
  - wr_en=0, wr_clear=0, wr_x=wr_y=0, busy=1.
- Tick: the tick counter runs in every state. tick=1 for one cycle when the count equals DIVISOR-1, then the count wraps to 0.
- All write outputs (wr_x, wr_y, wr_en, wr_clear) are registered.
- IDLE, on tick:
  - size_q = brush_size clamped to [1, min(SIZE_MAX, W_RES, H_RES)]; 0 maps to 1.
  - dx = -s if left only, +s if right only, 0 if neither or both; dy likewise for up/down. Diagonals are allowed.
  - s = STEP while the hold count < HOLD_TICKS, else 4*STEP.
  - The hold count increments when (dx,dy) is nonzero and equals the previous tick's direction; otherwise it resets to 1 (0 if no button).
  - New cursor is clamped to x in [0, W_RES-size_q], y in [0, H_RES-size_q]. The clamp also applies when only the size changes.
  - Then, if paint_en=1, go to PAINT.
- PAINT: scans size_q × size_q pixels in row-major order from the new cursor, one per cycle.
  - The first write is registered one cycle after the tick edge.
  - wr_en is high for exactly size_q² consecutive cycles with wr_clear=0, then the block returns to IDLE.
- CLEAR: emits (0,0), (1,0), ..., (W_RES-1,H_RES-1), one per cycle, W_RES*H_RES contiguous writes with wr_clear=1, then IDLE.
- Priority:
  - clear_req in IDLE wins over a simultaneous tick: go to CLEAR, with no move and no paint.
  - clear_req in PAINT aborts the paint; the next cycle begins CLEAR at (0,0).
  - clear_req during CLEAR is ignored; the clear does not restart.
- Ticks that occur outside IDLE are dropped. Movement and size do not change, and the hold count is unaffected.
- Mid-operation reset: everything returns to reset values, and a full CLEAR runs after release.
- Width rules: all coordinate arithmetic is done in COORD_W+1 bits signed before clamping. No wrap-around at the edges is permitted.

Decomposition:
- Package paint_pkg holds:
  - the state enum {IDLE, PAINT, CLEAR};
  - direction encoding;
  - the clamp helper function.
- Sub-module rect_scanner: loads base x/y plus width/height and a start strobe. It emits x/y, valid and done, one pixel per cycle, and takes an abort input. It is shared by PAINT and CLEAR.

Test Plan:
Test parameters: W_RES=16, H_RES=8, DIVISOR=4, STEP=2, SIZE_DEF=2, SIZE_MAX=4, HOLD_TICKS=3.
1. Release reset -> busy=1, 128 writes with wr_clear=1 in raster order (0,0) through (15,7), then busy=0 and cursor=(7,3).
2. right_n=0 held for 4 ticks -> cursor_x goes 9, 11, 13, then 14 (the 4th tick steps 8 and is clamped to 16-2).
3. From (7,3), up_n=left_n=0 held for 2 ticks -> cursor (5,1), then (3,0) with y clamped.
4. From (7,3), paint_en=1, brush_size=3, no buttons, one tick -> 9 writes (7,3), (8,3), (9,3), (7,4), ..., (9,5) with wr_clear=0; busy falls after the 9th write.
5. clear_req=1 on the 4th PAINT write -> remaining paint writes are dropped; the next cycle begins (0,0) with wr_clear=1 and 128 writes; a clear_req pulse mid-clear is ignored.
6. brush_size=0 -> painted square is 1×1. brush_size=31 with cursor at (14,6) -> size 4, cursor clamped to (12,4), 16 writes.
